duc_mixer: RTL

- Final DUC stage. Sits directly downstream of the third interpolator's saturated output.
- Multiplies each real baseband sample by cos(phase) from an internal NCO (phase accumulator plus quarter-wave cosine LUT), shifting the signal to IF.
- Produces rounded, saturated samples for the DAC path.
- Valid/ready streaming on both sides, 3-stage pipeline, full backpressure support.

---
 rtl/duc_mixer_pkg.sv | 45 ++++
 rtl/duc_mixer_if.sv | 26 ++
 rtl/nco_cos_lut.sv | 51 +++++
 rtl/duc_mixer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/duc_mixer_pkg.sv
// Shared widths, quadrant encoding, LFSR constants and rounding/saturation helpers for the
// DUC mixer.
package duc_mixer_pkg;

  localparam int unsigned DefDataWidth    = 16;
  localparam int unsigned DefOutWidth     = 16;
  localparam int unsigned DefPhaseWidth   = 24;
  localparam int unsigned DefLutAddrWidth = 10;
  localparam int unsigned DefLutWidth     = 16;
  localparam int unsigned ProdWidth       = DefDataWidth + DefLutWidth;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LfsrPoly = 16'hB400;
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  // One guard bit above the product so the rounding add cannot wrap.
  typedef logic signed [ProdWidth:0] wide_t;

  function automatic logic signed [DefOutWidth-1:0] sat_out(input wide_t v);
    wide_t hi;
    wide_t lo;
    logic signed [DefOutWidth-1:0] res;
    hi = wide_t'((1 << (DefOutWidth - 1)) - 1);
    lo = -hi - wide_t'(1);
    if (v > hi) begin
      res = hi[DefOutWidth-1:0];
    end else if (v < lo) begin
      res = lo[DefOutWidth-1:0];
    end else begin
      res = v[DefOutWidth-1:0];
    end
    return res;
  endfunction

  function automatic logic signed [DefOutWidth-1:0] sat_round(
    input logic signed [ProdWidth-1:0] product
  );
    wide_t s;
    s = wide_t'(product) + wide_t'(1 << (DefLutWidth - 2));
    return sat_out(s >>> (DefLutWidth - 1));
  endfunction

endpackage

// File: rtl/duc_mixer_if.sv
// Valid/ready sample streams into and out of the DUC mixer; slave is the mixer side.
interface duc_mixer_if
  import duc_mixer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned OUT_WIDTH  = DefOutWidth
);

  logic signed [DATA_WIDTH-1:0] src_data_in;
  logic                         src_valid_in;
  logic                         src_ready_out;
  logic signed [OUT_WIDTH-1:0]  dst_data_out;
  logic                         dst_valid_out;
  logic                         dst_ready_in;

  modport slave (
    input  src_data_in, src_valid_in, dst_ready_in,
    output src_ready_out, dst_data_out, dst_valid_out
  );

  modport master (
    output src_data_in, src_valid_in, dst_ready_in,
    input  src_ready_out, dst_data_out, dst_valid_out
  );

endinterface

// File: rtl/nco_cos_lut.sv
// Combinational cosine lookup: quarter-wave table built at elaboration plus quadrant
// folding to cover the full cycle.
module nco_cos_lut
  import duc_mixer_pkg::*;
#(
  parameter int unsigned LUT_ADDR_WIDTH = DefLutAddrWidth,
  parameter int unsigned LUT_WIDTH      = DefLutWidth
) (
  input  logic        [LUT_ADDR_WIDTH-1:0] addr_i,
  output logic signed [LUT_WIDTH-1:0]      cos_o
);

  localparam int unsigned N        = 1 << LUT_ADDR_WIDTH;
  localparam int unsigned Quarter  = N / 4;
  localparam int unsigned IdxWidth = LUT_ADDR_WIDTH - 1;

  function automatic logic signed [LUT_WIDTH-1:0] cos_entry(input int k);
    real amp;
    real ang;
    amp = real'((1 << (LUT_WIDTH - 1)) - 1);
    ang = 2.0 * 3.141592653589793 * real'(k) / real'(N);
    return LUT_WIDTH'($rtoi(amp * $cos(ang) + 0.5));
  endfunction

  logic signed [LUT_WIDTH-1:0] tab [Quarter+1];

  for (genvar k = 0; k <= Quarter; k++) begin : g_tab
    localparam logic signed [LUT_WIDTH-1:0] Entry = cos_entry(k);
    assign tab[k] = Entry;
  end

  quadrant_e            quad;
  logic [IdxWidth-1:0]  off;
  logic [IdxWidth-1:0]  mirror;

  assign quad   = quadrant_e'(addr_i[LUT_ADDR_WIDTH-1 -: 2]);
  assign off    = {1'b0, addr_i[LUT_ADDR_WIDTH-3:0]};
  assign mirror = IdxWidth'(Quarter) - off;

  always_comb begin
    cos_o = '0;
    unique case (quad)
      Q0:      cos_o = tab[off];
      Q1:      cos_o = -tab[mirror];
      Q2:      cos_o = -tab[off];
      Q3:      cos_o = tab[mirror];
      default: cos_o = '0;
    endcase
  end

endmodule

// File: rtl/duc_mixer.sv
// Final DUC stage: 3-stage valid/ready pipeline mixing baseband samples with an NCO cosine.
// Define DUC_MIXER_DITHER_EN to add LFSR phase dither ahead of the table address truncation.
module duc_mixer
  import duc_mixer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned OUT_WIDTH      = DefOutWidth,
  parameter int unsigned PHASE_WIDTH    = DefPhaseWidth,
  parameter int unsigned LUT_ADDR_WIDTH = DefLutAddrWidth,
  parameter int unsigned LUT_WIDTH      = DefLutWidth
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   bypass,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic                   ftw_load,
  input  logic                   phase_reset,
  duc_mixer_if.slave             stream_io
);

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic s1_byp_q, s1_byp_d, s2_byp_q, s2_byp_d;
  logic signed [DATA_WIDTH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
  logic [LUT_ADDR_WIDTH-1:0]    s1_addr_q, s1_addr_d;
  logic signed [LUT_WIDTH-1:0]  s2_cos_q, s2_cos_d;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic [PHASE_WIDTH-1:0]       acc_q, acc_d, ftw_q, ftw_d;

  logic adv1, adv2, adv3, accept;
  logic [LUT_ADDR_WIDTH-1:0]              addr_next;
  logic signed [LUT_WIDTH-1:0]            lut_cos;
  logic signed [DATA_WIDTH+LUT_WIDTH-1:0] prod;

  // Backpressure ripples combinationally from the output so bubbles collapse.
  assign adv3   = !v3_q || stream_io.dst_ready_in;
  assign adv2   = !v2_q || adv3;
  assign adv1   = !v1_q || adv2;
  assign accept = stream_io.src_valid_in && adv1;

  assign stream_io.src_ready_out = adv1;
  assign stream_io.dst_data_out  = out_q;
  assign stream_io.dst_valid_out = v3_q;

`ifdef DUC_MIXER_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign addr_next = LUT_ADDR_WIDTH'(
      (acc_q + PHASE_WIDTH'(lfsr_q[PHASE_WIDTH-LUT_ADDR_WIDTH-1:0]))
      >> (PHASE_WIDTH - LUT_ADDR_WIDTH));

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept && !bypass) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrPoly : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign addr_next = acc_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
`endif

  nco_cos_lut #(
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
    .LUT_WIDTH     (LUT_WIDTH)
  ) u_cos_lut (
    .addr_i(s1_addr_q),
    .cos_o (lut_cos)
  );

  assign prod = (DATA_WIDTH + LUT_WIDTH)'(s2_data_q) * (DATA_WIDTH + LUT_WIDTH)'(s2_cos_q);

  always_comb begin
    v1_d      = v1_q;
    v2_d      = v2_q;
    v3_d      = v3_q;
    s1_data_d = s1_data_q;
    s1_addr_d = s1_addr_q;
    s1_byp_d  = s1_byp_q;
    s2_data_d = s2_data_q;
    s2_cos_d  = s2_cos_q;
    s2_byp_d  = s2_byp_q;
    out_d     = out_q;
    acc_d     = acc_q;
    ftw_d     = ftw_load ? ftw : ftw_q;

    if (adv1) begin
      v1_d = stream_io.src_valid_in;
    end
    // Only the table address of the sampled phase is needed downstream.
    if (accept) begin
      s1_data_d = stream_io.src_data_in;
      s1_addr_d = addr_next;
      s1_byp_d  = bypass;
    end
    // A clear wins over the increment even when it coincides with an accept.
    if (phase_reset) begin
      acc_d = '0;
    end else if (accept && !bypass) begin
      acc_d = acc_q + ftw_q;
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_data_d = s1_data_q;
        s2_cos_d  = lut_cos;
        s2_byp_d  = s1_byp_q;
      end
    end

    if (adv3) begin
      v3_d = v2_q;
      if (v2_q) begin
        out_d = s2_byp_q ? sat_out(wide_t'(s2_data_q)) : sat_round(prod);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_data_q <= '0;
      s1_addr_q <= '0;
      s1_byp_q  <= 1'b0;
      s2_data_q <= '0;
      s2_cos_q  <= '0;
      s2_byp_q  <= 1'b0;
      out_q     <= '0;
      acc_q     <= '0;
      ftw_q     <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      s1_data_q <= s1_data_d;
      s1_addr_q <= s1_addr_d;
      s1_byp_q  <= s1_byp_d;
      s2_data_q <= s2_data_d;
      s2_cos_q  <= s2_cos_d;
      s2_byp_q  <= s2_byp_d;
      out_q     <= out_d;
      acc_q     <= acc_d;
      ftw_q     <= ftw_d;
    end
  end

endmodule
